// File: rtl/ifetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage and its immediate generator.
package ifetch_unit_pkg;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] PCSEL_SEQ  = 2'b00;
   localparam logic [1:0] PCSEL_REL  = 2'b01;
   localparam logic [1:0] PCSEL_JALR = 2'b10;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_FETCH = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_imm_gen.sv
// Combinational immediate generator: sign-extended immediate selected by the opcode of ir.
module ifetch_unit_imm_gen
   import ifetch_unit_pkg::*;
(
   input  logic [31:0] ir,
   output logic [31:0] imm_c
);

   always_comb begin
      imm_c = '0;
      case (ir[6:0])
         OP_IMM, OP_LOAD, OP_JALR: imm_c = {{20{ir[31]}}, ir[31:20]};
         OP_STORE:                 imm_c = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         OP_BRANCH:                imm_c = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         OP_LUI:                   imm_c = {ir[31:12], 12'b0};
         OP_JAL:                   imm_c = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         OP_REG:                   imm_c = '0;
         default:                  imm_c = '0;
      endcase
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns pc, pc0 and ir, fetches over a req/ack port with wait states,
// and applies the control unit's pc_write / ir_write strobes.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int unsigned IMEM_AW  = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ir_write,
   input  logic               pc_write,
   input  logic [1:0]         pc_sel,
   input  logic [31:0]        alu_f,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   input  logic               imem_ack,
   output logic               fetch_busy,
   output logic [31:0]        ir,
   output logic [6:0]         opcode,
   output logic [2:0]         funct3,
   output logic [6:0]         funct7,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic [4:0]         rd,
   output logic [31:0]        imm,
   output logic [31:0]        pc,
   output logic [31:0]        pc0,
   output logic               misalign
);

   fetch_state_t state, state_next;
   logic         load_pc0;
   logic         load_ir;
   logic [31:0]  pc_target;
   logic         pc_update;
   logic         target_bad;

   // Next-state and fetch strobes
   always_comb begin
      state_next = state;
      load_pc0   = 1'b0;
      load_ir    = 1'b0;
      case (state)
         S_IDLE: begin
            if (ir_write) begin
               state_next = S_FETCH;
               load_pc0   = 1'b1;
            end
         end
         S_FETCH: begin
            if (imem_ack) begin
               state_next = S_IDLE;
               load_ir    = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Next-PC selection, all from pre-edge values
   always_comb begin
      pc_target = pc;
      case (pc_sel)
         PCSEL_SEQ:  pc_target = pc + 32'd4;
         PCSEL_REL:  pc_target = pc0 + imm;
         PCSEL_JALR: pc_target = alu_f & ~32'h0000_0001;
         default:    pc_target = pc;
      endcase
      pc_update  = pc_write && (pc_sel != 2'b11);
      target_bad = (pc_target[1:0] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         imem_req   <= 1'b0;
         fetch_busy <= 1'b0;
         pc         <= RESET_PC;
         pc0        <= '0;
         ir         <= NOP;
         misalign   <= 1'b0;
      end else begin
         state      <= state_next;
         imem_req   <= (state_next == S_FETCH);
         fetch_busy <= (state_next == S_FETCH);
         if (load_pc0) pc0 <= pc;
         if (load_ir)  ir  <= imem_rdata;
         // A misaligned target is rejected; the flag stays set until reset
         if (pc_update) begin
            if (target_bad) misalign <= 1'b1;
            else            pc       <= pc_target;
         end
      end
   end

   assign imem_addr = pc0[IMEM_AW+1:2];
   assign opcode    = ir[6:0];
   assign funct3    = ir[14:12];
   assign funct7    = ir[31:25];
   assign rs1       = ir[19:15];
   assign rs2       = ir[24:20];
   assign rd        = ir[11:7];

   ifetch_unit_imm_gen u_imm_gen (
      .ir    (ir),
      .imm_c (imm)
   );

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: scenario tasks with a queue of expected fetch results.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ir_write;
   logic        pc_write;
   logic [1:0]  pc_sel;
   logic [31:0] alu_f;
   logic        imem_req;
   logic [5:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        fetch_busy;
   logic [31:0] ir;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] imm;
   logic [31:0] pc;
   logic [31:0] pc0;
   logic        misalign;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] imm;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ifetch_unit #(.IMEM_AW(6), .RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_sel     (pc_sel),
      .alu_f      (alu_f),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .fetch_busy (fetch_busy),
      .ir         (ir),
      .opcode     (opcode),
      .funct3     (funct3),
      .funct7     (funct7),
      .rs1        (rs1),
      .rs2        (rs2),
      .rd         (rd),
      .imm        (imm),
      .pc         (pc),
      .pc0        (pc0),
      .misalign   (misalign)
   );

   // One fetch: strobe in IDLE, ws wait states, then ack; result pushed now and popped after ack
   task automatic fetch(input logic [31:0] word, input int ws, input logic pcw, input logic [1:0] sel,
                        input logic [31:0] exp_imm, input logic [31:0] exp_pc0, input bit extra);
      int   req_cycles;
      exp_t e;
      exp_t got;
      @(negedge clk);
      ir_write = 1'b1; pc_write = pcw; pc_sel = sel;
      e.ir = word; e.imm = exp_imm;
      exp_q.push_back(e);
      @(negedge clk);
      ir_write = 1'b0; pc_write = 1'b0;
      req_cycles = 0;
      for (int i = 0; i <= ws; i++) begin
         if (imem_req === 1'b1 && fetch_busy === 1'b1) req_cycles++;
         if (i == 0) begin
            checks++;
            if (imem_addr !== exp_pc0[7:2]) begin
               errors++; $display("FAIL imem_addr: got %h expected %h", imem_addr, exp_pc0[7:2]);
            end
         end
         ir_write = (extra && i == 1);
         if (i == ws) begin imem_ack = 1'b1; imem_rdata = word; end
         else         begin imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF; end
         @(negedge clk);
      end
      imem_ack = 1'b0; ir_write = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      checks++;
      if (req_cycles != ws + 1) begin
         errors++; $display("FAIL req_cycles: got %0d expected %0d", req_cycles, ws + 1);
      end
      checks++;
      if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin
         errors++; $display("FAIL req_drop: got req=%b busy=%b expected 0 0", imem_req, fetch_busy);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++; $display("FAIL scoreboard: queue empty expected 1 entry");
      end else begin
         got = exp_q.pop_front();
         if (ir !== got.ir || imm !== got.imm) begin
            errors++;
            $display("FAIL fetch_result: got ir=%h imm=%h expected ir=%h imm=%h", ir, imm, got.ir, got.imm);
         end
      end
      checks++;
      if (pc0 !== exp_pc0) begin
         errors++; $display("FAIL pc0: got %h expected %h", pc0, exp_pc0);
      end
      if (extra) begin
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b0) begin
            errors++; $display("FAIL extra_ir_write: got req=%b expected 0", imem_req);
         end
      end
   endtask

   task automatic pc_op(input logic [1:0] sel, input logic [31:0] alu);
      @(negedge clk);
      pc_write = 1'b1; pc_sel = sel; alu_f = alu;
      @(negedge clk);
      pc_write = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ir_write = 1'b0; pc_write = 1'b0; pc_sel = 2'b00;
      alu_f = '0; imem_rdata = '0; imem_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (pc !== 32'h0 || pc0 !== 32'h0 || ir !== 32'h0000_0013) begin
         errors++; $display("FAIL reset_regs: got pc=%h pc0=%h ir=%h expected 0 0 00000013", pc, pc0, ir);
      end
      checks++;
      if (imem_req !== 1'b0 || fetch_busy !== 1'b0 || misalign !== 1'b0 || imm !== 32'h0) begin
         errors++;
         $display("FAIL reset_flags: got req=%b busy=%b mis=%b imm=%h expected 0 0 0 0", imem_req, fetch_busy, misalign, imm);
      end
   endtask

   task automatic test_first_fetch();
      fetch(32'h0050_0093, 0, 1'b1, 2'b00, 32'd5, 32'h0, 1'b0);
      checks++;
      if (pc !== 32'h4) begin errors++; $display("FAIL first_pc: got %h expected 00000004", pc); end
      checks++;
      if (rd !== 5'd1 || rs1 !== 5'd0 || opcode !== 7'h13 || funct3 !== 3'd0) begin
         errors++; $display("FAIL first_fields: got rd=%0d rs1=%0d op=%h f3=%0d expected 1 0 13 0", rd, rs1, opcode, funct3);
      end
   endtask

   task automatic test_wait_states();
      // sw x5, -8(x2) with three wait states and a stray ir_write mid-fetch
      fetch(32'hFE51_2C23, 3, 1'b1, 2'b00, 32'hFFFF_FFF8, 32'h4, 1'b1);
      checks++;
      if (pc !== 32'h8) begin errors++; $display("FAIL ws_pc: got %h expected 00000008", pc); end
      checks++;
      if (rs1 !== 5'd2 || rs2 !== 5'd5 || funct3 !== 3'd2 || funct7 !== 7'h7F) begin
         errors++; $display("FAIL ws_fields: got rs1=%0d rs2=%0d f3=%0d f7=%h expected 2 5 2 7f", rs1, rs2, funct3, funct7);
      end
   endtask

   task automatic test_branch();
      fetch(32'hFE00_0EE3, 0, 1'b1, 2'b00, 32'hFFFF_FFFC, 32'h8, 1'b0);
      checks++;
      if (pc !== 32'hC) begin errors++; $display("FAIL br_fetch_pc: got %h expected 0000000c", pc); end
      @(negedge clk);
      checks++;
      if (pc !== 32'hC) begin errors++; $display("FAIL br_not_taken: got %h expected 0000000c", pc); end
      pc_op(2'b01, 32'h0);
      checks++;
      if (pc !== 32'h4) begin errors++; $display("FAIL br_taken: got %h expected 00000004", pc); end
   endtask

   task automatic test_jalr();
      pc_op(2'b10, 32'h0000_0021);
      checks++;
      if (pc !== 32'h20) begin errors++; $display("FAIL jalr_target: got %h expected 00000020", pc); end
      pc_op(2'b10, 32'hFFFF_FFFC);
      checks++;
      if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jalr_high: got %h expected fffffffc", pc); end
      pc_op(2'b00, 32'h0);
      checks++;
      if (pc !== 32'h0 || misalign !== 1'b0) begin
         errors++; $display("FAIL pc_wrap: got pc=%h mis=%b expected 0 0", pc, misalign);
      end
      pc_op(2'b11, 32'h0000_0040);
      checks++;
      if (pc !== 32'h0) begin errors++; $display("FAIL sel_hold: got %h expected 00000000", pc); end
      pc_op(2'b10, 32'h0000_0022);
      checks++;
      if (pc !== 32'h0 || misalign !== 1'b1) begin
         errors++; $display("FAIL misalign_set: got pc=%h mis=%b expected 0 1", pc, misalign);
      end
      pc_op(2'b00, 32'h0);
      checks++;
      if (pc !== 32'h4 || misalign !== 1'b1) begin
         errors++; $display("FAIL misalign_sticky: got pc=%h mis=%b expected 4 1", pc, misalign);
      end
   endtask

   task automatic test_decode();
      logic [31:0] words [4] = '{32'h0080_006F, 32'h0000_007F, 32'h1234_50B7, 32'hFFF0_0093};
      logic [31:0] imms  [4] = '{32'd8, 32'd0, 32'h1234_5000, 32'hFFFF_FFFF};
      for (int k = 0; k < 4; k++) fetch(words[k], k % 2, 1'b0, 2'b00, imms[k], 32'h4, 1'b0);
      checks++;
      if (pc !== 32'h4) begin errors++; $display("FAIL decode_pc_hold: got %h expected 00000004", pc); end
   endtask

   task automatic test_reset_mid_fetch();
      @(negedge clk);
      ir_write = 1'b1;
      @(negedge clk);
      ir_write = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
      @(negedge clk);
      imem_ack = 1'b0;
      checks++;
      if (ir !== 32'h0000_0013 || pc !== 32'h0 || pc0 !== 32'h0) begin
         errors++; $display("FAIL rst_fetch_regs: got ir=%h pc=%h pc0=%h expected 00000013 0 0", ir, pc, pc0);
      end
      checks++;
      if (imem_req !== 1'b0 || fetch_busy !== 1'b0 || misalign !== 1'b0) begin
         errors++; $display("FAIL rst_fetch_flags: got req=%b busy=%b mis=%b expected 0 0 0", imem_req, fetch_busy, misalign);
      end
      fetch(32'h00A0_0113, 0, 1'b1, 2'b00, 32'd10, 32'h0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_wait_states();
      test_branch();
      test_jalr();
      test_decode();
      test_reset_mid_fetch();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multi-cycle control unit.
- Owns the PC, the saved PC of the current instruction (PC0) and the IR.
- Fetches from instruction memory through a req/ack handshake that allows wait states.
- Presents decoded fields (opcode, funct3, funct7, register indices) and the sign-extended immediate to the CU and datapath.
- Applies the CU's PC_Write / IR_Write strobes, with next-PC selection for sequential, branch/jal and jalr flows.

Parameters:
- IMEM_AW, 6, instruction-memory word-address width.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- ir_write  input  1  CU strobe: start a fetch at the current PC
- pc_write  input  1  CU strobe: update PC
- pc_sel  input  2  next-PC source: 00 PC+4, 01 PC0+imm, 10 alu_f with bit0 cleared, 11 reserved (hold PC)
- alu_f  input  32  ALU result, used as the jalr target
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  IMEM_AW  word address = pc0[IMEM_AW+1:2]
- imem_rdata  input  32  instruction word, valid while imem_ack is high
- imem_ack  input  1  memory response strobe
- fetch_busy  output  1  high while a fetch is outstanding; the CU stalls on it
- ir  output  32  instruction register
- opcode  output  7  ir[6:0]
- funct3  output  3  ir[14:12]
- funct7  output  7  ir[31:25]
- rs1  output  5  ir[19:15]
- rs2  output  5  ir[24:20]
- rd  output  5  ir[11:7]
- imm  output  32  sign-extended immediate of ir
- pc  output  32  program counter
- pc0  output  32  address of the instruction held or being fetched into ir
- misalign  output  1  sticky flag: a rejected PC target was not word-aligned

Behaviour:
- Reset, synchronous, active-high. Wins over every other input.
  - pc = RESET_PC, pc0 = 0, ir = 32'h0000_0013 (NOP)
  - state IDLE, imem_req = 0, fetch_busy = 0, misalign = 0
  - Reset mid-fetch abandons the fetch; an ack arriving afterwards in IDLE is ignored.
- FSM states: IDLE, FETCH.
  - IDLE, ir_write = 1:
    - pc0 <= pc
    - go to FETCH
    - imem_req = 1 and fetch_busy = 1 from the next cycle
  - FETCH:
    - imem_req held high until imem_ack is sampled high.
    - On ack: ir <= imem_rdata, imem_req <= 0, return to IDLE.
    - The new ir and decoded fields are visible the cycle after ack.
    - Minimum latency, ir_write to new ir: 2 cycles (ack in the first FETCH cycle).
  - ir_write while in FETCH: ignored, no restart.
- PC update, when pc_write = 1:
  - 00: pc <= pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - 01: pc <= pc0 + imm.
  - 10: pc <= alu_f & ~1.
  - 11: pc unchanged.
  - If the selected target has bit1 or bit0 set after masking: pc is not updated and misalign <= 1 (sticky until rst).
  - pc_write is honoured in both IDLE and FETCH. A fetch in progress already latched its address in pc0 and is unaffected.
- Simultaneous ir_write and pc_write in IDLE (the normal fetch step):
  - pc0 <= old pc, the fetch uses the old pc, pc <= selected target.
  - Each selection is computed from pre-edge values.
- imm is combinational from ir, by opcode:
  - I-type (0010011, 0000011, 1100111): sext(ir[31:20])
  - S (0100011): sext({ir[31:25], ir[11:7]})
  - B (1100011): sext({ir[31], ir[7], ir[30:25], ir[11:8], 0})
  - U (0110111): {ir[31:12], 12'b0}
  - J (1101111): sext({ir[31], ir[19:12], ir[20], ir[30:21], 0})
  - any other opcode: 0
- Decoded fields are pure slices of ir and change only when ir loads.
- No further outstanding request: at most one fetch in flight.

Decomposition:
- Shared package holds:
  - opcode constants: OP_IMM, OP_REG, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR
  - pc_sel encodings: PCSEL_SEQ, PCSEL_REL, PCSEL_JALR
  - NOP constant
  - FSM state encoding
- One natural sub-module: imm_gen, combinational ir -> imm, reused by the datapath.

Test Plan:
- Reset then ir_write + pc_write (sel 00) with ack in the first FETCH cycle, imem_rdata = 32'h00500093 -> pc0 = 0, pc = 4, ir = 32'h00500093 two cycles after ir_write, rd = 1, imm = 5.
- Memory with 3 wait states -> imem_req and fetch_busy high for exactly 4 cycles; an extra ir_write pulse during FETCH is ignored; ir is updated once.
- ir = beq (32'hFE000EE3, imm = -4), pc0 = 8, pc_write sel 01 -> pc = 4; with pc_write low (ZF = 0), pc stays 12.
- jalr: alu_f = 32'h0000_0021, sel 10 -> pc = 32'h20. Then alu_f = 32'h22 -> pc unchanged, misalign = 1 and stays 1 until rst.
- pc = 32'hFFFF_FFFC, sel 00 -> pc = 0. J-type ir = 32'h0080006F -> imm = 8. Unknown opcode -> imm = 0.
- rst asserted during FETCH, late imem_ack the cycle after -> ir = 32'h0000_0013, pc = RESET_PC, imem_req = 0, state IDLE.
